miss_fill_sequencer: RTL and testbench
======================================

# miss_fill_sequencer

Sequences a cache miss from acceptance to line installation. For a dirty victim it first writes the line back to main memory, then fetches the new line. It streams the returned beats into the chosen way and finally installs the tag/valid bit. It sits between the cache flow-control FSM, which supplies the miss and the eviction target from the LRU policy, the way array, and the main-memory port.

## Interface
Parameters:
- NUM_WAYS, 4, number of ways; power of two, ≥2
- DATA_WIDTH, 32, bits per memory/way beat
- BLOCK_SIZE, 32, line size in bytes; power of two, multiple of DATA_WIDTH/8
- ADDRESS_WIDTH, 32, byte address width

Derived values:
- WORDS = BLOCK_SIZE/(DATA_WIDTH/8)
- OFF = $clog2(BLOCK_SIZE)
- WB = max(1,$clog2(WORDS))
- WAYB = $clog2(NUM_WAYS)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- miss_valid  in  1  miss request from flow-control FSM
- miss_ready  out  1  sequencer can accept a miss
- miss_addr  in  ADDRESS_WIDTH  missing byte address
- victim_way  in  WAYB  way chosen for eviction
- victim_dirty  in  1  victim line must be written back
- victim_addr  in  ADDRESS_WIDTH  address of the evicted line
- mem_req_valid  out  1  memory command valid
- mem_req_ready  in  1  memory accepts the command
- mem_req_write  out  1  1 = writeback, 0 = line read
- mem_req_addr  out  ADDRESS_WIDTH  block-aligned line address
- mem_wdata_valid  out  1  writeback beat valid
- mem_wdata_ready  in  1  memory accepts the beat
- mem_wdata  out  DATA_WIDTH  writeback beat
- mem_rdata_valid  in  1  fill beat valid; memory cannot be stalled
- mem_rdata  in  DATA_WIDTH  fill beat
- way_sel  out  WAYB  target way for all way accesses
- way_rd_en  out  1  read one word of way_sel
- way_word  out  WB  word index for way read/write
- way_rd_data  in  DATA_WIDTH  read data, valid 1 cycle after way_rd_en
- way_wr_en  out  1  write mem_rdata into way_sel[way_word]
- way_wr_data  out  DATA_WIDTH  write data
- install_en  out  1  one-cycle pulse: set tag and valid of way_sel
- install_tag  out  ADDRESS_WIDTH-OFF  miss_addr[ADDRESS_WIDTH-1:OFF]
- busy  out  1  state ≠ IDLE
- fill_done  out  1  one-cycle pulse, coincident with install_en

## Operation
- States: IDLE, WB_REQ, WB_RD, WB_SEND, FILL_REQ, FILL_DATA, INSTALL.
- IDLE: miss_ready=1. On miss_valid, latch miss_addr, victim_way, victim_dirty, victim_addr and clear the word counter. Next state is WB_REQ if dirty, else FILL_REQ. miss_ready=0 in every other state; miss_valid is ignored there.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_req_addr=victim_addr with low OFF bits zeroed. Fields stay stable until mem_req_ready, then go to WB_RD.
- WB_RD: way_rd_en=1 for exactly one cycle with way_word=cnt, then go to WB_SEND.
- WB_SEND: register way_rd_data on entry. Hold mem_wdata_valid=1 and mem_wdata stable until mem_wdata_ready. On the handshake, if cnt==WORDS-1 clear cnt and go to FILL_REQ; else cnt+1 and go to WB_RD.
- FILL_REQ: as WB_REQ but with mem_req_write=0 and the aligned miss_addr. Go to FILL_DATA on mem_req_ready.
- FILL_DATA: way_wr_en = mem_rdata_valid, way_word=cnt, way_wr_data=mem_rdata (combinational, same cycle). cnt increments per beat. The cycle after the beat with cnt==WORDS-1 is INSTALL.
- INSTALL: install_en=1 and fill_done=1 for one cycle, then go to IDLE.
- way_sel = latched victim_way in all non-IDLE states.
- Counter width is WB. Wrap is never reached because the FSM exits at WORDS-1. For WORDS=1 the counter is constant 0 and each data phase is a single beat.
- mem_rdata_valid outside FILL_DATA is ignored: no way write.

## Timing
- Reset: FSM goes to IDLE, cnt=0, latches cleared. All outputs are 0 except miss_ready=1.
- Reset mid-operation abandons the transaction immediately:
  - no install_en or fill_done pulse
  - the way line is left partially written
  - the caller owns re-issuing the miss
- Clean miss with mem_req_ready=1 and a beat every cycle starting the cycle after the request handshake:
  - accept at cycle 0
  - request at cycle 1
  - beats at cycles 2..WORDS+1
  - install at cycle WORDS+2
  - miss_ready=1 again at WORDS+3
- Dirty writeback takes a minimum of 2 cycles per beat (WB_RD + WB_SEND), plus 1 request cycle.
- Back-to-back misses: a miss_valid held high is accepted on the first IDLE cycle after INSTALL.

## Test plan
- Clean miss: miss_addr=0x0000_1234, victim_way=2, memory returns 0xA0..0xA7 one per cycle -> mem_req_addr=0x0000_1220 with write=0; way 2 words 0..7 written 0xA0..0xA7; install_tag=0x0000091; fill_done exactly 8 cycles after the first beat... pulse at cycle 10 from accept.
- Dirty miss: victim_addr=0x0000_4000, way 1 holds 0x10..0x17 -> WB request at 0x4000 with write=1; mem_wdata sequence 0x10..0x17 in order; then a fill read; exactly one install_en.
- Backpressure: mem_req_ready low for 5 cycles, then mem_wdata_ready toggling -> request/data fields stable while stalled; no beat dropped or duplicated; cnt advances only on handshakes.
- Reset at the 4th fill beat -> next cycle all outputs at reset values; miss_ready=1; no fill_done; a new miss then completes normally.
- miss_valid asserted while busy with a different address -> ignored; the original line completes; the second miss is accepted only in IDLE.
- Spurious mem_rdata_valid in IDLE/WB_SEND -> no way_wr_en.

Source files
------------

// File: rtl/miss_fill_sequencer.sv
// miss_fill_sequencer
// Carries one cache miss from acceptance to line installation. A dirty
// victim is first written back beat by beat (read a word from the way
// array, then offer it to memory), then the new line is requested and
// its returned beats are streamed straight into the victim way. The
// sequence ends with a one-cycle tag/valid install pulse.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   miss_*              miss request (valid/ready) with address and victim info
//   mem_req_*           line command to main memory (valid/ready)
//   mem_wdata_*         writeback beats to main memory (valid/ready)
//   mem_rdata_*         fill beats from main memory (valid only, no stall)
//   way_*               way array access: one-word read, one-word write
//   install_en/_tag     set tag and valid of way_sel
//   busy, fill_done     status; fill_done coincides with install_en
//   dbg_state           current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; while valid is high and ready low the payload does not change
// and valid is not withdrawn. mem_rdata_valid has no ready: each valid cycle
// in FILL_DATA is one beat.
module miss_fill_sequencer #(
    parameter int NUM_WAYS      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    localparam int WORDS = BLOCK_SIZE / (DATA_WIDTH / 8),
    localparam int OFF   = $clog2(BLOCK_SIZE),
    localparam int WB    = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int WAYB  = $clog2(NUM_WAYS),
    localparam int TAGW  = ADDRESS_WIDTH - OFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    input  logic [WAYB-1:0]          victim_way,
    input  logic                     victim_dirty,
    input  logic [ADDRESS_WIDTH-1:0] victim_addr,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    output logic                     mem_wdata_valid,
    input  logic                     mem_wdata_ready,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [WAYB-1:0]          way_sel,
    output logic                     way_rd_en,
    output logic [WB-1:0]            way_word,
    input  logic [DATA_WIDTH-1:0]    way_rd_data,
    output logic                     way_wr_en,
    output logic [DATA_WIDTH-1:0]    way_wr_data,
    output logic                     install_en,
    output logic [TAGW-1:0]          install_tag,
    output logic                     busy,
    output logic                     fill_done,
    output logic [2:0]               dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WB_REQ    = 3'd1;
    localparam logic [2:0] S_WB_RD     = 3'd2;
    localparam logic [2:0] S_WB_SEND   = 3'd3;
    localparam logic [2:0] S_FILL_REQ  = 3'd4;
    localparam logic [2:0] S_FILL_DATA = 3'd5;
    localparam logic [2:0] S_INSTALL   = 3'd6;

    localparam logic [WB-1:0] CNT_LAST = WB'(WORDS - 1);

    logic [2:0]            state_q, state_d;
    logic [WB-1:0]         cnt_q, cnt_d;
    logic [TAGW-1:0]       miss_tag_q, miss_tag_d;
    logic [TAGW-1:0]       victim_tag_q, victim_tag_d;
    logic [WAYB-1:0]       way_q, way_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    // High in the first WB_SEND cycle: the way read data is only on
    // way_rd_data then, so it is forwarded directly and captured.
    logic                  fresh_q, fresh_d;

    // Only line addresses are kept; the byte offset bits never matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[OFF-1:0], victim_addr[OFF-1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_tag_d   = miss_tag_q;
        victim_tag_d = victim_tag_q;
        way_d        = way_q;
        wdata_d      = wdata_q;
        fresh_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
                    miss_tag_d   = miss_addr[ADDRESS_WIDTH-1:OFF];
                    victim_tag_d = victim_addr[ADDRESS_WIDTH-1:OFF];
                    way_d        = victim_way;
                    cnt_d        = '0;
                    state_d      = victim_dirty ? S_WB_REQ : S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                if (mem_req_ready) state_d = S_WB_RD;
            end
            S_WB_RD: begin
                fresh_d = 1'b1;
                state_d = S_WB_SEND;
            end
            S_WB_SEND: begin
                if (fresh_q) wdata_d = way_rd_data;
                if (mem_wdata_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FILL_REQ;
                    end else begin
                        cnt_d   = cnt_q + WB'(1);
                        state_d = S_WB_RD;
                    end
                end
            end
            S_FILL_REQ: begin
                if (mem_req_ready) state_d = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                if (mem_rdata_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_INSTALL;
                    end else begin
                        cnt_d = cnt_q + WB'(1);
                    end
                end
            end
            S_INSTALL: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            miss_tag_q   <= '0;
            victim_tag_q <= '0;
            way_q        <= '0;
            wdata_q      <= '0;
            fresh_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_tag_q   <= miss_tag_d;
            victim_tag_q <= victim_tag_d;
            way_q        <= way_d;
            wdata_q      <= wdata_d;
            fresh_q      <= fresh_d;
        end
    end

    always_comb begin
        miss_ready      = (state_q == S_IDLE);
        busy            = (state_q != S_IDLE);
        mem_req_valid   = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
        mem_req_write   = (state_q == S_WB_REQ);
        mem_req_addr    = '0;
        if (state_q == S_WB_REQ)   mem_req_addr = {victim_tag_q, {OFF{1'b0}}};
        if (state_q == S_FILL_REQ) mem_req_addr = {miss_tag_q, {OFF{1'b0}}};
        mem_wdata_valid = (state_q == S_WB_SEND);
        mem_wdata       = '0;
        if (state_q == S_WB_SEND) mem_wdata = fresh_q ? way_rd_data : wdata_q;
        way_sel         = (state_q == S_IDLE) ? '0 : way_q;
        way_rd_en       = (state_q == S_WB_RD);
        way_word        = cnt_q;
        way_wr_en       = (state_q == S_FILL_DATA) && mem_rdata_valid;
        way_wr_data     = (state_q == S_FILL_DATA) ? mem_rdata : '0;
        install_en      = (state_q == S_INSTALL);
        fill_done       = (state_q == S_INSTALL);
        install_tag     = miss_tag_q;
        dbg_state       = state_q;
    end

endmodule

// File: tb/tb_miss_fill_sequencer.sv
// Bench for miss_fill_sequencer: a way-array model and a main-memory
// responder surround the DUT; each miss is predicted by a line-level
// reference (expected request list, expected writeback beats, resulting
// way contents) and compared after the install pulse.
module tb_miss_fill_sequencer;
  localparam int NUM_WAYS      = 4;
  localparam int DATA_WIDTH    = 32;
  localparam int BLOCK_SIZE    = 32;
  localparam int ADDRESS_WIDTH = 32;
  localparam int WORDS = BLOCK_SIZE / (DATA_WIDTH / 8);
  localparam int OFF   = $clog2(BLOCK_SIZE);
  localparam int WB    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAYB  = $clog2(NUM_WAYS);
  localparam int TAGW  = ADDRESS_WIDTH - OFF;

  typedef logic [ADDRESS_WIDTH:0] req_t;

  logic                     clk;
  logic                     reset;
  logic                     miss_valid;
  logic                     miss_ready;
  logic [ADDRESS_WIDTH-1:0] miss_addr;
  logic [WAYB-1:0]          victim_way;
  logic                     victim_dirty;
  logic [ADDRESS_WIDTH-1:0] victim_addr;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_write;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr;
  logic                     mem_wdata_valid;
  logic                     mem_wdata_ready;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_rdata_valid;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic [WAYB-1:0]          way_sel;
  logic                     way_rd_en;
  logic [WB-1:0]            way_word;
  logic [DATA_WIDTH-1:0]    way_rd_data;
  logic                     way_wr_en;
  logic [DATA_WIDTH-1:0]    way_wr_data;
  logic                     install_en;
  logic [TAGW-1:0]          install_tag;
  logic                     busy;
  logic                     fill_done;
  logic [2:0]               dbg_state;

  miss_fill_sequencer #(
    .NUM_WAYS(NUM_WAYS), .DATA_WIDTH(DATA_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE), .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .way_sel(way_sel), .way_rd_en(way_rd_en), .way_word(way_word),
    .way_rd_data(way_rd_data), .way_wr_en(way_wr_en), .way_wr_data(way_wr_data),
    .install_en(install_en), .install_tag(install_tag), .busy(busy),
    .fill_done(fill_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_WIDTH-1:0] init_word(input int w, input int i);
    return DATA_WIDTH'((w << 4) | i);
  endfunction

  // ---------------- environment state ----------------
  logic [DATA_WIDTH-1:0] way_mem  [NUM_WAYS][WORDS];
  logic [DATA_WIDTH-1:0] ref_way  [NUM_WAYS][WORDS];
  logic [DATA_WIDTH-1:0] fill_data[WORDS];
  int   mode = 0;        // 0: always ready, 1: req stall + toggling wready, 2: random
  int   req_stall = 0;
  bit   spur_en = 1'b0;
  int   req_wait = 0;

  req_t                  req_log[$];
  logic [DATA_WIDTH-1:0] wd_log[$];
  int   cyc = 0, acc_cnt = 0, acc_cycle = 0, inst_cnt = 0, inst_cycle = 0;
  logic [TAGW-1:0] inst_tag = '0;
  logic [WAYB-1:0] inst_way = '0;
  int   bad_wr = 0, stab_err = 0, pulse_err = 0;
  bit   rd_active = 1'b0;
  int   beat_idx = 0;
  bit   req_stalled = 1'b0, wd_stalled = 1'b0;
  req_t req_prev = '0;
  logic [DATA_WIDTH-1:0] wd_prev = '0;

  // memory responder: drives its inputs away from the sampling edge
  always @(negedge clk) begin
    if (mem_req_valid) begin
      mem_req_ready <= (req_wait >= req_stall) &&
                       ((mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1);
      req_wait <= req_wait + 1;
    end else begin
      mem_req_ready <= 1'b0;
      req_wait <= 0;
    end
    if (mode == 0)      mem_wdata_ready <= 1'b1;
    else if (mode == 1) mem_wdata_ready <= ~mem_wdata_ready;
    else                mem_wdata_ready <= 1'($urandom_range(0, 1));
    if (rd_active && beat_idx < WORDS) begin
      mem_rdata_valid <= (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rdata       <= fill_data[beat_idx];
    end else begin
      mem_rdata_valid <= spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata       <= $urandom;
    end
  end

  // way array model and observation of every handshake
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      rd_active   <= 1'b0;
      beat_idx    <= 0;
      req_stalled <= 1'b0;
      wd_stalled  <= 1'b0;
      way_rd_data <= '0;
      for (int w = 0; w < NUM_WAYS; w++)
        for (int i = 0; i < WORDS; i++)
          way_mem[w][i] <= init_word(w, i);
    end else begin
      if (way_rd_en) way_rd_data <= way_mem[way_sel][way_word];
      if (way_wr_en) begin
        way_mem[way_sel][way_word] <= way_wr_data;
        if (!(rd_active && mem_rdata_valid)) bad_wr <= bad_wr + 1;
      end
      if (rd_active && mem_rdata_valid) begin
        beat_idx <= beat_idx + 1;
        if (beat_idx == WORDS - 1) rd_active <= 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        req_log.push_back({mem_req_write, mem_req_addr});
        if (!mem_req_write) begin
          rd_active <= 1'b1;
          beat_idx  <= 0;
        end
      end
      if (mem_wdata_valid && mem_wdata_ready) wd_log.push_back(mem_wdata);
      if (req_stalled && !(mem_req_valid && {mem_req_write, mem_req_addr} == req_prev))
        stab_err <= stab_err + 1;
      if (wd_stalled && !(mem_wdata_valid && mem_wdata == wd_prev))
        stab_err <= stab_err + 1;
      req_stalled <= mem_req_valid && !mem_req_ready;
      req_prev    <= {mem_req_write, mem_req_addr};
      wd_stalled  <= mem_wdata_valid && !mem_wdata_ready;
      wd_prev     <= mem_wdata;
      if (miss_valid && miss_ready) begin
        acc_cnt   <= acc_cnt + 1;
        acc_cycle <= cyc;
      end
      if (install_en) begin
        inst_cnt   <= inst_cnt + 1;
        inst_cycle <= cyc;
        inst_tag   <= install_tag;
        inst_way   <= way_sel;
      end
      if (install_en !== fill_done) pulse_err <= pulse_err + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0, n_txn = 0;
  req_t                  exp_req[$];
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [TAGW-1:0]       exp_tag;
  int exp_way = 0, req_base = 0, wd_base = 0, acc_base = 0, inst_base = 0;
  int a_inst = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int w = 0; w < NUM_WAYS; w++)
      for (int i = 0; i < WORDS; i++)
        ref_way[w][i] = init_word(w, i);
  endtask

  // Present a miss on the bus and predict its whole outcome.
  task automatic prep(input logic [ADDRESS_WIDTH-1:0] addr, input int way,
                      input bit dirty, input logic [ADDRESS_WIDTH-1:0] vaddr,
                      input int fill_base);
    logic [ADDRESS_WIDTH-1:0] mask;
    mask = ~ADDRESS_WIDTH'(BLOCK_SIZE - 1);
    miss_addr = addr; victim_way = WAYB'(way);
    victim_dirty = dirty; victim_addr = vaddr;
    for (int i = 0; i < WORDS; i++)
      fill_data[i] = (fill_base >= 0) ? DATA_WIDTH'(fill_base + i) : DATA_WIDTH'($urandom);
    exp_req.delete();
    exp_q.delete();
    if (dirty) begin
      exp_req.push_back({1'b1, vaddr & mask});
      for (int i = 0; i < WORDS; i++) exp_q.push_back(ref_way[way][i]);
    end
    exp_req.push_back({1'b0, addr & mask});
    for (int i = 0; i < WORDS; i++) ref_way[way][i] = fill_data[i];
    exp_tag   = TAGW'(addr >> OFF);
    exp_way   = way;
    req_base  = req_log.size();
    wd_base   = wd_log.size();
    acc_base  = acc_cnt;
    inst_base = inst_cnt;
  endtask

  task automatic accept();
    int n;
    n = 0;
    miss_valid = 1'b1;
    while (acc_cnt == acc_base && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", acc_cnt - acc_base, 1);
    miss_valid = 1'b0;
  endtask

  task automatic finish(input string name);
    int n, nd;
    n = 0;
    while (inst_cnt == inst_base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, ":done"}, inst_cnt - inst_base, 1);
    check({name, ":tag"}, inst_tag, exp_tag);
    check({name, ":way"}, inst_way, exp_way);
    check({name, ":nreq"}, req_log.size() - req_base, exp_req.size());
    for (int k = 0; k < exp_req.size(); k++)
      if (req_base + k < req_log.size())
        check($sformatf("%s:req%0d", name, k), req_log[req_base + k], exp_req[k]);
    check({name, ":nwd"}, wd_log.size() - wd_base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (wd_base + k < wd_log.size())
        check($sformatf("%s:wd%0d", name, k), wd_log[wd_base + k], exp_q[k]);
    for (int i = 0; i < WORDS; i++)
      check($sformatf("%s:line%0d", name, i), way_mem[exp_way][i], ref_way[exp_way][i]);
    nd = 0;
    for (int w = 0; w < NUM_WAYS; w++)
      for (int i = 0; i < WORDS; i++)
        if (way_mem[w][i] !== ref_way[w][i]) nd++;
    check({name, ":other_ways"}, nd, 0);
    check({name, ":stray_wr"}, bad_wr, 0);
    check({name, ":stable"}, stab_err, 0);
    check({name, ":pulse"}, pulse_err, 0);
    n_txn++;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ":ctl"}, {miss_ready, busy, mem_req_valid, mem_req_write, mem_wdata_valid,
                           way_rd_en, way_wr_en, install_en, fill_done}, 9'b100000000);
    check({name, ":state"}, {dbg_state, way_sel, way_word}, 0);
    check({name, ":req_addr"}, mem_req_addr, 0);
    check({name, ":wdata"}, mem_wdata, 0);
    check({name, ":wr_data"}, way_wr_data, 0);
    check({name, ":tag"}, install_tag, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; victim_way = '0;
    victim_dirty = 1'b0; victim_addr = '0;
    mem_req_ready = 1'b0; mem_wdata_ready = 1'b0;
    mem_rdata_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    ref_reset();
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // clean miss, one beat per cycle
    prep(32'h0000_1234, 2, 1'b0, 32'h0000_0000, 'hA0);
    accept();
    finish("clean");
    check("clean:latency", inst_cycle - acc_cycle, WORDS + 2);
    check("clean:tag91", inst_tag, 'h91);
    check("clean:req_addr", req_log[req_base], {1'b0, 32'h0000_1220});
    check("clean:ready_again", miss_ready, 1);

    // dirty miss with spurious read-data valids outside the fill
    spur_en = 1'b1;
    prep(32'h0000_2468, 1, 1'b1, 32'h0000_4000, -1);
    accept();
    finish("dirty");
    check("dirty:wb_req", req_log[req_base], {1'b1, 32'h0000_4000});
    if (wd_log.size() > wd_base) check("dirty:wd_first", wd_log[wd_base], 'h10);

    // backpressure on request and writeback data
    mode = 1; req_stall = 5;
    prep(32'h0001_3579, 2, 1'b1, 32'h0000_9A60, -1);
    accept();
    finish("stall");
    mode = 0; req_stall = 0; spur_en = 1'b0;

    // reset while the 4th fill beat is on the bus
    prep(32'h0000_3000, 0, 1'b0, 32'h0, -1);
    accept();
    n = 0;
    while (!(rd_active && beat_idx == 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst:reached_beat3", beat_idx, 3);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    ref_reset();
    repeat (4) @(negedge clk);
    check("rst:no_install", inst_cnt - inst_base, 0);
    prep(32'h0000_3040, 0, 1'b0, 32'h0, -1);
    accept();
    finish("after_rst");

    // second miss held high while busy: only taken once back in IDLE
    prep(32'h0000_5500, 0, 1'b0, 32'h0, -1);
    accept();
    repeat (2) @(negedge clk);
    miss_valid = 1'b1; miss_addr = 32'h0000_7777; victim_way = 2'd3;
    victim_dirty = 1'b1; victim_addr = 32'h0000_C000;
    finish("busy_a");
    a_inst = inst_cycle;
    prep(32'h0000_7777, 3, 1'b1, 32'h0000_C000, -1);
    accept();
    check("busy:b_accept_cycle", acc_cycle - a_inst, 1);
    finish("busy_b");

    // randomized misses with random stalls and spurious beats
    mode = 2; spur_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      req_stall = $urandom_range(0, 2);
      prep($urandom, $urandom_range(0, NUM_WAYS - 1), 1'($urandom_range(0, 1)),
           $urandom, -1);
      accept();
      finish($sformatf("rnd%0d", t));
    end
    mode = 0; spur_en = 1'b0;

    repeat (4) @(negedge clk);
    check("install_total", inst_cnt, n_txn);
    check("end_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
